dmawr_frame_sequencer: RTL and testbench
========================================

Name: dmawr_frame_sequencer

Overview:
- Sequences the DMA write engine for HiSPi-sourced image frames.
- Takes per-line requests from the pixel stream front end (SOF-tagged) and turns each into one write descriptor (address, byte size, last flag) for the DMA write datapath.
- Tracks line index and buffer ring position, raises end-of-frame interrupt, and flags stream/engine protocol errors.
- Sits between the HiSPi receiver's line-ready handshake and the AXI-stream DMA write engine; configured from registers on the sysclk domain.

Parameters:
ADDR_WIDTH, 64, host buffer address width
NUMB_BUFFER, 4, maximum number of frame buffers in the ring (2..8)
SIZE_WIDTH, 16, line byte-size and pitch width
LINE_CNT_WIDTH, 12, lines-per-frame counter width
FRAME_CNT_WIDTH, 16, frame counter width

Ports:
sysclk  in  1  single clock
sysrst  in  1  asynchronous active-high reset
cfg_enable  in  1  sequencer enable
cfg_buffer_count  in  3  buffers in use; 0 is treated as 1; values >NUMB_BUFFER clamp to NUMB_BUFFER
cfg_buffer_base  in  NUMB_BUFFER*ADDR_WIDTH  base address per buffer; buffer i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
cfg_line_pitch  in  SIZE_WIDTH  byte stride between lines
cfg_line_size  in  SIZE_WIDTH  bytes per line
cfg_lines_per_frame  in  LINE_CNT_WIDTH  lines per frame; 0 is treated as 1
cfg_err_clr  in  1  pulse; clears sticky errors
s_line_valid  in  1  line request from front end
s_line_sof  in  1  request is first line of frame
s_line_ready  out  1  request accepted
desc_valid  out  1  descriptor valid
desc_ready  in  1  write engine accepts descriptor
desc_addr  out  ADDR_WIDTH  line destination address
desc_size  out  SIZE_WIDTH  line byte count
desc_last  out  1  last line of frame
desc_done  in  1  pulse; engine finished the outstanding descriptor
irq_eof  out  1  one-cycle end-of-frame pulse
status_buffer  out  3  buffer index currently or last written
status_frame_cnt  out  FRAME_CNT_WIDTH  completed frames; wraps
status_busy  out  1  state is not IDLE
err_sync  out  1  sticky: non-SOF request while waiting for SOF
err_abort  out  1  sticky: SOF received mid-frame
err_done  out  1  sticky: desc_done outside WAIT_DONE

Behaviour:
- Reset: all outputs 0; state IDLE; buffer index 0; line index 0; frame counter 0.
- States: IDLE, WAIT_SOF, WAIT_LINE, ISSUE, WAIT_DONE, EOF.
- IDLE: s_line_ready=0. Goes to WAIT_SOF when cfg_enable=1.
- WAIT_SOF: s_line_ready=1.
  - Request with sof=1: latch config (base[buf], pitch, size, lines), set addr=base[buf], line=0, go to ISSUE.
  - Request with sof=0: request is consumed and dropped; err_sync set.
  - cfg_enable=0: go to IDLE.
- WAIT_LINE: s_line_ready=1.
  - Request with sof=0: go to ISSUE.
  - Request with sof=1: err_abort set; restart at line 0, addr=latched base of the same buffer, config re-latched; go to ISSUE.
  - cfg_enable is not sampled here; the frame completes first.
- ISSUE: desc_valid=1.
  - desc_addr, desc_size, desc_last (line==lines-1) stay stable until desc_ready.
  - Handshake cycle: go to WAIT_DONE.
- Request-accept to desc_valid latency is 1 cycle. s_line_ready=0 in ISSUE, WAIT_DONE and EOF.
- WAIT_DONE, on desc_done:
  - If last line, go to EOF.
  - Otherwise line+1, addr+=pitch (accumulator, no multiplier, modulo 2^ADDR_WIDTH), go to WAIT_LINE.
- EOF (one cycle):
  - irq_eof=1; status_frame_cnt+1.
  - Buffer index advances: buf+1, wrapping to 0 at effective buffer count.
  - Next state: WAIT_SOF if cfg_enable=1, else IDLE.
- status_buffer updates at SOF latch.
- desc_done seen in any state except WAIT_DONE is ignored and sets err_done.
- Sticky errors: cfg_err_clr clears them; a set in the same cycle as a clear wins.
- Config changes mid-frame have no effect until the next SOF latch.
- Reset mid-frame returns to IDLE immediately; an outstanding descriptor is abandoned.

Test Plan:
- 2 buffers (0x1000_0000, 0x2000_0000), pitch 0x800, size 0x600, 3 lines; SOF + 2 lines, done after each -> addrs 0x1000_0000/0x1000_0800/0x1000_1000, desc_last on the 3rd only, irq_eof once, frame_cnt=1; next frame starts at 0x2000_0000; third frame wraps back to 0x1000_0000.
- desc_ready held low 5 cycles -> desc_valid/addr/size stable all 5 cycles; s_line_ready=0 until desc_done.
- Non-SOF request while in WAIT_SOF -> dropped, err_sync=1, no descriptor; cfg_err_clr pulse -> err_sync=0.
- SOF arriving after line 1 of a 3-line frame -> err_abort=1, next desc_addr=base of the same buffer, desc_last on the 3rd line after restart.
- cfg_enable dropped during line 1 -> frame completes, irq_eof pulses, state reaches IDLE, s_line_ready=0; stray desc_done in IDLE -> err_done=1.
- sysrst asserted during ISSUE -> desc_valid=0 asynchronously, all counters 0, buffer index 0.

Source files
------------

// File: rtl/dmawr_frame_sequencer.sv
// Frame sequencer for the HiSPi DMA write path: turns SOF-tagged line requests
// into one write descriptor per line and tracks buffer ring, frame count and errors.
module dmawr_frame_sequencer #(
    parameter int ADDR_WIDTH      = 64,
    parameter int NUMB_BUFFER     = 4,
    parameter int SIZE_WIDTH      = 16,
    parameter int LINE_CNT_WIDTH  = 12,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                              sysclk,
    input  logic                              sysrst,
    input  logic                              cfg_enable,
    input  logic [2:0]                        cfg_buffer_count,
    input  logic [NUMB_BUFFER*ADDR_WIDTH-1:0] cfg_buffer_base,
    input  logic [SIZE_WIDTH-1:0]             cfg_line_pitch,
    input  logic [SIZE_WIDTH-1:0]             cfg_line_size,
    input  logic [LINE_CNT_WIDTH-1:0]         cfg_lines_per_frame,
    input  logic                              cfg_err_clr,
    input  logic                              s_line_valid,
    input  logic                              s_line_sof,
    output logic                              s_line_ready,
    output logic                              desc_valid,
    input  logic                              desc_ready,
    output logic [ADDR_WIDTH-1:0]             desc_addr,
    output logic [SIZE_WIDTH-1:0]             desc_size,
    output logic                              desc_last,
    input  logic                              desc_done,
    output logic                              irq_eof,
    output logic [2:0]                        status_buffer,
    output logic [FRAME_CNT_WIDTH-1:0]        status_frame_cnt,
    output logic                              status_busy,
    output logic                              err_sync,
    output logic                              err_abort,
    output logic                              err_done
);

    localparam int BUF_W = (NUMB_BUFFER > 1) ? $clog2(NUMB_BUFFER) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        WAIT_LINE,
        ISSUE,
        WAIT_DONE,
        EOF
    } state_t;

    state_t                    state;
    logic [BUF_W-1:0]          buf_idx;
    logic [3:0]                buf_cnt_lat;
    logic [SIZE_WIDTH-1:0]     pitch_lat;
    logic [SIZE_WIDTH-1:0]     size_lat;
    logic [LINE_CNT_WIDTH-1:0] lines_lat;
    logic [LINE_CNT_WIDTH-1:0] line_idx;
    logic [ADDR_WIDTH-1:0]     addr_acc;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic [2:0]                status_buf;

    logic [ADDR_WIDTH-1:0]     base_arr [NUMB_BUFFER];
    logic [3:0]                buf_cnt_eff;
    logic [LINE_CNT_WIDTH-1:0] lines_eff;
    logic [3:0]                buf_inc;
    logic                      buf_wrap;
    logic                      is_last;
    logic                      sync_set;
    logic                      abort_set;
    logic                      done_set;

    for (genvar gi = 0; gi < NUMB_BUFFER; gi++) begin : g_base
        assign base_arr[gi] = cfg_buffer_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Zero buffers/lines behave as one; buffer count clamps to the ring size.
    always_comb begin
        buf_cnt_eff = {1'b0, cfg_buffer_count};
        if (cfg_buffer_count == 3'd0)
            buf_cnt_eff = 4'd1;
        else if ({1'b0, cfg_buffer_count} > 4'(NUMB_BUFFER))
            buf_cnt_eff = 4'(NUMB_BUFFER);
    end

    assign lines_eff = (cfg_lines_per_frame == '0) ? LINE_CNT_WIDTH'(1) : cfg_lines_per_frame;
    assign buf_inc   = 4'(buf_idx) + 4'd1;
    assign buf_wrap  = (buf_inc >= buf_cnt_lat);
    assign is_last   = (line_idx == lines_lat - LINE_CNT_WIDTH'(1));

    assign sync_set  = (state == WAIT_SOF) && s_line_valid && !s_line_sof;
    assign abort_set = (state == WAIT_LINE) && s_line_valid && s_line_sof;
    assign done_set  = desc_done && (state != WAIT_DONE);

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state       <= IDLE;
            buf_idx     <= '0;
            buf_cnt_lat <= 4'd1;
            pitch_lat   <= '0;
            size_lat    <= '0;
            lines_lat   <= LINE_CNT_WIDTH'(1);
            line_idx    <= '0;
            addr_acc    <= '0;
            frame_cnt   <= '0;
            status_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_enable)
                        state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (s_line_valid) begin
                        if (s_line_sof) begin
                            addr_acc    <= base_arr[buf_idx];
                            pitch_lat   <= cfg_line_pitch;
                            size_lat    <= cfg_line_size;
                            lines_lat   <= lines_eff;
                            buf_cnt_lat <= buf_cnt_eff;
                            line_idx    <= '0;
                            status_buf  <= 3'(buf_idx);
                            state       <= ISSUE;
                        end
                    end else if (!cfg_enable) begin
                        state <= IDLE;
                    end
                end
                // A SOF here aborts the frame and restarts it in the same buffer.
                WAIT_LINE: begin
                    if (s_line_valid) begin
                        if (s_line_sof) begin
                            addr_acc    <= base_arr[buf_idx];
                            pitch_lat   <= cfg_line_pitch;
                            size_lat    <= cfg_line_size;
                            lines_lat   <= lines_eff;
                            buf_cnt_lat <= buf_cnt_eff;
                            line_idx    <= '0;
                            status_buf  <= 3'(buf_idx);
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (desc_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (desc_done) begin
                        if (is_last) begin
                            state <= EOF;
                        end else begin
                            line_idx <= line_idx + LINE_CNT_WIDTH'(1);
                            addr_acc <= addr_acc + ADDR_WIDTH'(pitch_lat);
                            state    <= WAIT_LINE;
                        end
                    end
                end
                EOF: begin
                    frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
                    buf_idx   <= buf_wrap ? '0 : buf_idx + BUF_W'(1);
                    state     <= cfg_enable ? WAIT_SOF : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky errors: a new error in the same cycle as a clear stays set.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            err_sync  <= 1'b0;
            err_abort <= 1'b0;
            err_done  <= 1'b0;
        end else begin
            err_sync  <= sync_set  | (err_sync  & ~cfg_err_clr);
            err_abort <= abort_set | (err_abort & ~cfg_err_clr);
            err_done  <= done_set  | (err_done  & ~cfg_err_clr);
        end
    end

    assign s_line_ready     = (state == WAIT_SOF) || (state == WAIT_LINE);
    assign desc_valid       = (state == ISSUE);
    assign desc_addr        = addr_acc;
    assign desc_size        = size_lat;
    assign desc_last        = (state == ISSUE) && is_last;
    assign irq_eof          = (state == EOF);
    assign status_buffer    = status_buf;
    assign status_frame_cnt = frame_cnt;
    assign status_busy      = (state != IDLE);

endmodule

// File: tb/tb_dmawr_frame_sequencer.sv
// Scoreboard bench for dmawr_frame_sequencer: expected descriptors are queued by
// the stimulus thread and checked by a monitor at every descriptor handshake.
module tb_dmawr_frame_sequencer;

    localparam int ADDR_WIDTH      = 64;
    localparam int NUMB_BUFFER     = 4;
    localparam int SIZE_WIDTH      = 16;
    localparam int LINE_CNT_WIDTH  = 12;
    localparam int FRAME_CNT_WIDTH = 16;

    localparam logic [63:0] BASE0 = 64'h1000_0000;
    localparam logic [63:0] BASE1 = 64'h2000_0000;
    localparam logic [15:0] SIZE  = 16'h0600;

    logic                              sysclk = 1'b0;
    logic                              sysrst = 1'b0;
    logic                              cfg_enable = 1'b0;
    logic [2:0]                        cfg_buffer_count = 3'd2;
    logic [NUMB_BUFFER*ADDR_WIDTH-1:0] cfg_buffer_base = '0;
    logic [SIZE_WIDTH-1:0]             cfg_line_pitch = 16'h0800;
    logic [SIZE_WIDTH-1:0]             cfg_line_size = SIZE;
    logic [LINE_CNT_WIDTH-1:0]         cfg_lines_per_frame = 12'd3;
    logic                              cfg_err_clr = 1'b0;
    logic                              s_line_valid = 1'b0;
    logic                              s_line_sof = 1'b0;
    logic                              s_line_ready;
    logic                              desc_valid;
    logic                              desc_ready = 1'b0;
    logic [ADDR_WIDTH-1:0]             desc_addr;
    logic [SIZE_WIDTH-1:0]             desc_size;
    logic                              desc_last;
    logic                              desc_done = 1'b0;
    logic                              irq_eof;
    logic [2:0]                        status_buffer;
    logic [FRAME_CNT_WIDTH-1:0]        status_frame_cnt;
    logic                              status_busy;
    logic                              err_sync;
    logic                              err_abort;
    logic                              err_done;

    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] size;
        logic        last;
    } desc_t;

    desc_t expQ[$];
    desc_t expDesc;
    int    checks = 0;
    int    failures = 0;
    int    irqCount = 0;
    int    expIrq = 0;

    dmawr_frame_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUMB_BUFFER(NUMB_BUFFER),
        .SIZE_WIDTH(SIZE_WIDTH),
        .LINE_CNT_WIDTH(LINE_CNT_WIDTH),
        .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
    ) dut (
        .sysclk(sysclk),
        .sysrst(sysrst),
        .cfg_enable(cfg_enable),
        .cfg_buffer_count(cfg_buffer_count),
        .cfg_buffer_base(cfg_buffer_base),
        .cfg_line_pitch(cfg_line_pitch),
        .cfg_line_size(cfg_line_size),
        .cfg_lines_per_frame(cfg_lines_per_frame),
        .cfg_err_clr(cfg_err_clr),
        .s_line_valid(s_line_valid),
        .s_line_sof(s_line_sof),
        .s_line_ready(s_line_ready),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .desc_addr(desc_addr),
        .desc_size(desc_size),
        .desc_last(desc_last),
        .desc_done(desc_done),
        .irq_eof(irq_eof),
        .status_buffer(status_buffer),
        .status_frame_cnt(status_frame_cnt),
        .status_busy(status_busy),
        .err_sync(err_sync),
        .err_abort(err_abort),
        .err_done(err_done)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every descriptor handshake must match the oldest queued expectation.
    always @(negedge sysclk) begin
        if (!sysrst && desc_valid && desc_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_desc", desc_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                expDesc = expQ.pop_front();
                checkOutput("desc_addr", desc_addr, expDesc.addr);
                checkOutput("desc_size", 64'(desc_size), 64'(expDesc.size));
                checkOutput("desc_last", 64'(desc_last), 64'(expDesc.last));
            end
        end
    end

    always @(negedge sysclk) begin
        if (irq_eof)
            irqCount++;
    end

    task automatic waitCycle();
        @(posedge sysclk);
        #1;
    endtask

    task automatic sendLine(input logic sof);
        int n = 0;
        while (!s_line_ready && n < 100) begin
            waitCycle();
            n++;
        end
        if (!s_line_ready) begin
            checkOutput("line_ready_timeout", 64'(s_line_ready), 64'd1);
            return;
        end
        s_line_valid = 1'b1;
        s_line_sof   = sof;
        waitCycle();
        s_line_valid = 1'b0;
        s_line_sof   = 1'b0;
    endtask

    // One line: request, optional back-pressure with stability checks, handshake, done.
    task automatic applyStimulus(input logic sof, input logic [63:0] addr, input logic last, input int holdCycles);
        int n = 0;
        expQ.push_back('{addr: addr, size: SIZE, last: last});
        sendLine(sof);
        while (!desc_valid && n < 100) begin
            waitCycle();
            n++;
        end
        if (!desc_valid) begin
            checkOutput("desc_valid_timeout", 64'(desc_valid), 64'd1);
            return;
        end
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput("hold_valid", 64'(desc_valid), 64'd1);
            checkOutput("hold_addr", desc_addr, addr);
            checkOutput("hold_size", 64'(desc_size), 64'(SIZE));
            checkOutput("hold_line_ready", 64'(s_line_ready), 64'd0);
            waitCycle();
        end
        desc_ready = 1'b1;
        waitCycle();
        desc_ready = 1'b0;
        checkOutput("wait_done_line_ready", 64'(s_line_ready), 64'd0);
        checkOutput("wait_done_valid", 64'(desc_valid), 64'd0);
        desc_done = 1'b1;
        waitCycle();
        desc_done = 1'b0;
    endtask

    task automatic runFrame(input logic [63:0] base, input logic [2:0] expBuf, input int expFrames, input int hold);
        applyStimulus(1'b1, base, 1'b0, hold);
        checkOutput("status_buffer", 64'(status_buffer), 64'(expBuf));
        applyStimulus(1'b0, base + 64'h800, 1'b0, 0);
        applyStimulus(1'b0, base + 64'h1000, 1'b1, 0);
        expIrq++;
        waitCycle();
        waitCycle();
        checkOutput("irq_count", 64'(irqCount), 64'(expIrq));
        checkOutput("frame_cnt", 64'(status_frame_cnt), 64'(expFrames));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cfg_buffer_base[0*ADDR_WIDTH +: ADDR_WIDTH] = BASE0;
        cfg_buffer_base[1*ADDR_WIDTH +: ADDR_WIDTH] = BASE1;
        #1 sysrst = 1'b1;
        #20;
        checkOutput("rst_line_ready", 64'(s_line_ready), 64'd0);
        checkOutput("rst_desc_valid", 64'(desc_valid), 64'd0);
        checkOutput("rst_irq", 64'(irq_eof), 64'd0);
        checkOutput("rst_busy", 64'(status_busy), 64'd0);
        checkOutput("rst_frame_cnt", 64'(status_frame_cnt), 64'd0);
        checkOutput("rst_buffer", 64'(status_buffer), 64'd0);
        checkOutput("rst_errors", 64'({err_sync, err_abort, err_done}), 64'd0);
        waitCycle();
        sysrst = 1'b0;
        cfg_enable = 1'b1;

        // Three frames over a two-buffer ring; second frame back-pressures line 0.
        runFrame(BASE0, 3'd0, 1, 0);
        runFrame(BASE1, 3'd1, 2, 5);
        runFrame(BASE0, 3'd0, 3, 0);

        // Non-SOF request while waiting for SOF is dropped.
        sendLine(1'b0);
        waitCycle();
        checkOutput("sync_err", 64'(err_sync), 64'd1);
        checkOutput("sync_no_desc", 64'(desc_valid), 64'd0);
        checkOutput("sync_still_ready", 64'(s_line_ready), 64'd1);
        cfg_err_clr = 1'b1;
        waitCycle();
        cfg_err_clr = 1'b0;
        checkOutput("sync_cleared", 64'(err_sync), 64'd0);

        // Mid-frame SOF restarts the frame in buffer 1.
        applyStimulus(1'b1, BASE1, 1'b0, 0);
        applyStimulus(1'b0, BASE1 + 64'h800, 1'b0, 0);
        applyStimulus(1'b1, BASE1, 1'b0, 0);
        checkOutput("abort_err", 64'(err_abort), 64'd1);
        applyStimulus(1'b0, BASE1 + 64'h800, 1'b0, 0);
        applyStimulus(1'b0, BASE1 + 64'h1000, 1'b1, 0);
        expIrq++;
        waitCycle();
        waitCycle();
        checkOutput("abort_irq_count", 64'(irqCount), 64'(expIrq));
        checkOutput("abort_frame_cnt", 64'(status_frame_cnt), 64'd4);
        cfg_err_clr = 1'b1;
        waitCycle();
        cfg_err_clr = 1'b0;
        checkOutput("abort_cleared", 64'(err_abort), 64'd0);

        // Enable dropped mid-frame: frame completes, then sequencer idles.
        applyStimulus(1'b1, BASE0, 1'b0, 0);
        cfg_enable = 1'b0;
        applyStimulus(1'b0, BASE0 + 64'h800, 1'b0, 0);
        applyStimulus(1'b0, BASE0 + 64'h1000, 1'b1, 0);
        expIrq++;
        waitCycle();
        waitCycle();
        checkOutput("disable_irq_count", 64'(irqCount), 64'(expIrq));
        checkOutput("disable_frame_cnt", 64'(status_frame_cnt), 64'd5);
        checkOutput("disable_busy", 64'(status_busy), 64'd0);
        checkOutput("disable_line_ready", 64'(s_line_ready), 64'd0);
        desc_done = 1'b1;
        waitCycle();
        desc_done = 1'b0;
        checkOutput("stray_done_err", 64'(err_done), 64'd1);

        // Reset while a descriptor is being offered abandons it.
        cfg_enable = 1'b1;
        sendLine(1'b1);
        checkOutput("pre_rst_valid", 64'(desc_valid), 64'd1);
        checkOutput("pre_rst_addr", desc_addr, BASE1);
        #2 sysrst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(desc_valid), 64'd0);
        checkOutput("mid_rst_frame_cnt", 64'(status_frame_cnt), 64'd0);
        checkOutput("mid_rst_buffer", 64'(status_buffer), 64'd0);
        checkOutput("mid_rst_errors", 64'({err_sync, err_abort, err_done}), 64'd0);
        waitCycle();
        sysrst = 1'b0;
        runFrame(BASE0, 3'd0, 1, 0);

        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
